// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding control for the 5-stage pipeline, extended with
// branch-in-decode stalls, a single-entry multiply/divide scoreboard and a stall counter.
module hazard_scoreboard #(
    parameter int REG_W  = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             BranchD,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             MdOpD,
    input  logic             MdStartE,
    input  logic [REG_W-1:0] MdDestE,
    input  logic             StallClr,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MdBusy,
    output logic             MdWriteW,
    output logic [REG_W-1:0] MdWriteReg,
    output logic             MdOverlap,
    output logic [CNT_W-1:0] StallCount
);

    localparam int                MDC_W   = $clog2(MD_LAT + 1);
    localparam logic [MDC_W-1:0]  MD_LOAD = MDC_W'(MD_LAT);
    localparam logic [MDC_W-1:0]  MD_ONE  = MDC_W'(1);

    logic [MDC_W-1:0] mdCnt;
    logic [REG_W-1:0] mdDest;
    logic             lwStall;
    logic             branchStall;
    logic             mdStall;
    logic             stallAny;

    function automatic logic hitD(input logic [REG_W-1:0] r,
                                  input logic [REG_W-1:0] rs,
                                  input logic [REG_W-1:0] rt);
        return (r != '0) && ((r == rs) || (r == rt));
    endfunction

    // M-stage result is newer than W, so it wins when both match.
    function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src);
        if (RegWriteM && (WriteRegM != '0) && (src == WriteRegM))
            return 2'b10;
        else if (RegWriteW && (WriteRegW != '0) && (src == WriteRegW))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        ForwardAE = fwdSel(RsE);
        ForwardBE = fwdSel(RtE);
        ForwardAD = RegWriteM && (RsD != '0) && (RsD == WriteRegM);
        ForwardBD = RegWriteM && (RtD != '0) && (RtD == WriteRegM);
    end

    assign MdBusy     = (mdCnt != '0);
    assign MdWriteW   = (mdCnt == MD_ONE);
    assign MdWriteReg = MdWriteW ? mdDest : '0;

    // At mdCnt == 1 the register file write-first bypass covers the dependency.
    always_comb begin
        lwStall     = MemtoRegE && RegWriteE && hitD(WriteRegE, RsD, RtD);
        branchStall = BranchD && ((RegWriteE && hitD(WriteRegE, RsD, RtD)) ||
                                  (MemtoRegM && hitD(WriteRegM, RsD, RtD)));
        mdStall     = (MdOpD && (MdBusy || MdStartE)) ||
                      (MdStartE && hitD(MdDestE, RsD, RtD)) ||
                      ((mdCnt > MD_ONE) && hitD(mdDest, RsD, RtD));
        stallAny    = lwStall || branchStall || mdStall;
    end

    assign StallF = stallAny;
    assign StallD = stallAny;
    assign FlushE = stallAny;

    // A new issue is accepted only when idle; an issue while busy is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdCnt     <= '0;
            mdDest    <= '0;
            MdOverlap <= 1'b0;
        end else begin
            if (MdStartE && (mdCnt == '0)) begin
                mdCnt  <= MD_LOAD;
                mdDest <= MdDestE;
            end else if (mdCnt != '0) begin
                mdCnt <= mdCnt - MD_ONE;
            end
            if (MdStartE && (mdCnt != '0))
                MdOverlap <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            StallCount <= '0;
        else if (StallClr)
            StallCount <= '0;
        else if (StallD)
            StallCount <= satInc(StallCount);
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the 5-stage MIPS hazard/forwarding unit. It adds branch-in-decode hazard stalls and a scoreboard that tracks one outstanding multi-cycle multiply/divide write, stalling dependent decode instructions. It also keeps a saturating stall-cycle counter and a sticky overlap-error flag. It sits beside the pipeline and drives the stall, flush and forward-select controls.

Parameters:
REG_W, 5, register address width; register 0 is hardwired zero.
MD_LAT, 4, cycles from an MD issue in E to its writeback pulse; must be >= 2.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
BranchD  in  1  branch instruction in D
RsD, RtD  in  REG_W  D-stage source registers
RsE, RtE  in  REG_W  E-stage source registers
WriteRegE, WriteRegM, WriteRegW  in  REG_W  destination register per stage
RegWriteE, RegWriteM, RegWriteW  in  1  register write enable per stage
MemtoRegE, MemtoRegM  in  1  load in E / load in M
MdOpD  in  1  MD instruction in D
MdStartE  in  1  MD instruction valid in E this cycle
MdDestE  in  REG_W  MD destination register
StallClr  in  1  synchronous clear of StallCount
StallF, StallD, FlushE  out  1  stall fetch, stall decode, flush E
ForwardAD, ForwardBD  out  1  M-stage result forward to D comparator
ForwardAE, ForwardBE  out  2  E operand select: 00 regfile, 01 W, 10 M
MdBusy  out  1  MD operation outstanding
MdWriteW  out  1  one-cycle MD writeback strobe
MdWriteReg  out  REG_W  MD writeback register
MdOverlap  out  1  sticky error: MdStartE while busy
StallCount  out  CNT_W  saturating count of StallD cycles

Behaviour:
- Reset (async, rst_n=0): md_cnt=0, md_dest=0, MdOverlap=0, StallCount=0. Consequently MdBusy=0, MdWriteW=0 and MdWriteReg=0. Combinational outputs follow the inputs with the scoreboard idle.
- Definitions: "hitD(r)" means r != 0 and (r == RsD or r == RtD).
- ForwardAE:
  - 10 if RegWriteM, WriteRegM != 0 and RsE == WriteRegM.
  - Otherwise 01 if RegWriteW, WriteRegW != 0 and RsE == WriteRegW.
  - Otherwise 00.
  - M has priority over W.
- ForwardBE: same rule as ForwardAE, using RtE.
- ForwardAD = RegWriteM and RsD != 0 and RsD == WriteRegM. ForwardBD is the same using RtD.
- lwstall = MemtoRegE and RegWriteE and hitD(WriteRegE).
- branchstall = BranchD and ((RegWriteE and hitD(WriteRegE)) or (MemtoRegM and hitD(WriteRegM))).
- mdstall is asserted when either condition holds:
  - MdOpD and (MdBusy or MdStartE) — structural hazard.
  - (MdStartE and hitD(MdDestE)) or (md_cnt > 1 and hitD(md_dest)) — data hazard.
  - At md_cnt == 1 the register file write-first bypass supplies the value, so no stall.
- StallF = StallD = FlushE = lwstall or branchstall or mdstall. These are combinational, with no added latency.
- Scoreboard:
  - If MdStartE and md_cnt == 0: load md_cnt = MD_LAT and md_dest = MdDestE.
  - Otherwise, if md_cnt != 0, decrement md_cnt.
  - MdStartE while md_cnt != 0 sets MdOverlap (cleared only by reset). The new issue is ignored; the count continues.
- MdBusy = (md_cnt != 0).
- MdWriteW = (md_cnt == 1). MdWriteReg = md_dest whenever MdWriteW is high, otherwise 0.
- A back-to-back issue in the cycle after MdWriteW (md_cnt == 0) is legal.
- StallCount:
  - Each edge: if StallClr, load 0. Else, if StallD and the count is not all-ones, increment. At all-ones it holds.
  - StallClr has priority over increment.
- Reset mid-operation: the pending MD write is dropped, with no MdWriteW pulse.

Test Plan:
- Forwarding: RsE=RtE=8, with WriteRegM=8/RegWriteM=1 and WriteRegW=8/RegWriteW=1 -> ForwardAE=ForwardBE=10. Drop RegWriteM -> 01. Repeat with WriteReg*=0 -> 00.
- Load-use: MemtoRegE=1, RegWriteE=1, WriteRegE=9, RtD=9 -> StallF/StallD/FlushE=1 for that cycle. Set RsD=RtD=0 with WriteRegE=0 -> no stall.
- Branch: BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 -> stall. Move to M with MemtoRegM=1 -> stall. With MemtoRegM=0 -> no stall, ForwardAD=1.
- MD sequence, MD_LAT=4: MdStartE with MdDestE=12 at cycle 0 and RsD=12 -> stall cycles 0-3. MdBusy high cycles 1-4. MdWriteW=1 and MdWriteReg=12 at cycle 4 only, and StallD=0 at cycle 4. MdOpD during busy -> stall. Second MdStartE at cycle 2 -> MdOverlap=1 and the writeback stays at cycle 4.
- Counter, CNT_W=3: hold StallD high for 10 cycles -> StallCount saturates at 7. StallClr asserted together with StallD -> 0.
- Reset mid-op: deassert rst_n at md_cnt=2 -> MdBusy=0, StallCount=0 and MdOverlap=0 immediately (async). No MdWriteW pulse follows.
